// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator control path.
// State codes double as the status display value.
package rpn_pkg;

  localparam logic [2:0] STATUS_A   = 3'b001;
  localparam logic [2:0] STATUS_B   = 3'b010;
  localparam logic [2:0] STATUS_OP  = 3'b100;
  localparam logic [2:0] STATUS_RES = 3'b111;

  typedef enum logic [2:0] {
    S_A   = STATUS_A,
    S_B   = STATUS_B,
    S_OP  = STATUS_OP,
    S_RES = STATUS_RES
  } state_t;

  typedef enum logic {
    C_IDLE,
    C_RUN
  } conv_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a debounced level.
// History resets high so a level held through reset is not an event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic q;

  // previous-cycle copy of the level
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b1;
    else       q <= sig;
  end

  assign rise = sig & ~q;

endmodule

// File: rtl/rpn_sequencer.sv
// RPN calculator entry sequencer: load strobes, display select
// and start/done handshake with the binary-to-BCD converter.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enter,
  input  logic         undo,
  input  logic         display_format,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] result,
  input  logic         conv_done,
  output logic         load_a,
  output logic         load_b,
  output logic         load_op,
  output logic         show_result,
  output logic         conv_start,
  output logic [W-1:0] conv_value,
  output logic         disp_valid,
  output logic [2:0]   status
);

  logic         enter_ev;
  logic         undo_ev;
  state_t       state;
  state_t       state_n;
  conv_t        cst;
  conv_t        cst_n;
  logic         cv_ok;
  logic         cv_ok_n;
  logic [W-1:0] cval_n;
  logic [W-1:0] dv;
  logic         need;
  logic         start_n;
  logic         dvalid_n;
  logic         la_n;
  logic         lb_n;
  logic         lo_n;

  rise_detect u_enter (
    .clk   (clk),
    .reset (reset),
    .sig   (enter),
    .rise  (enter_ev)
  );

  rise_detect u_undo (
    .clk   (clk),
    .reset (reset),
    .sig   (undo),
    .rise  (undo_ev)
  );

  assign show_result = (state == S_RES);
  assign status      = state;
  assign dv          = show_result ? result : data_in;
  assign need        = display_format &
                       (~cv_ok | (dv != conv_value));

  // next entry state, strobes and converter handshake
  always_comb begin
    state_n = state;
    la_n    = 1'b0;
    lb_n    = 1'b0;
    lo_n    = 1'b0;
    priority case (1'b1)
      undo_ev: begin
        unique case (state)
          S_B:     state_n = S_A;
          S_OP:    state_n = S_B;
          S_RES:   state_n = S_OP;
          default: state_n = S_A;
        endcase
      end
      enter_ev: begin
        unique case (state)
          S_A: begin
            state_n = S_B;
            la_n    = 1'b1;
          end
          S_B: begin
            state_n = S_OP;
            lb_n    = 1'b1;
          end
          S_OP: begin
            state_n = S_RES;
            lo_n    = 1'b1;
          end
          default: state_n = S_A;
        endcase
      end
      default: state_n = state;
    endcase

    cst_n   = cst;
    cv_ok_n = cv_ok;
    cval_n  = conv_value;
    start_n = 1'b0;
    unique case (cst)
      C_IDLE: begin
        if (need) begin
          start_n = 1'b1;
          cval_n  = dv;
          cv_ok_n = 1'b0;
          cst_n   = C_RUN;
        end
      end
      default: begin
        if (conv_done) begin
          cv_ok_n = 1'b1;
          cst_n   = C_IDLE;
        end
      end
    endcase

    dvalid_n = ~display_format |
               ((cst_n == C_IDLE) & cv_ok_n & (dv == cval_n));
  end

  // register state and all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_A;
      load_a     <= 1'b0;
      load_b     <= 1'b0;
      load_op    <= 1'b0;
      cst        <= C_IDLE;
      cv_ok      <= 1'b0;
      conv_start <= 1'b0;
      conv_value <= '0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      load_a     <= la_n;
      load_b     <= lb_n;
      load_op    <= lo_n;
      cst        <= cst_n;
      cv_ok      <= cv_ok_n;
      conv_start <= start_n;
      conv_value <= cval_n;
      disp_valid <= dvalid_n;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: vector table for entry/undo,
// scripted sequences for reset and converter handshake.
module tb_rpn_sequencer;

  typedef struct {
    logic        e;
    logic        u;
    logic [15:0] d;
    logic [2:0]  st;
    logic [2:0]  sb;
  } vec_t;

  typedef struct {
    logic [2:0] sb;
    logic [2:0] st;
  } sexp_t;

  logic        clk;
  logic        reset;
  logic        enter;
  logic        undo;
  logic        fmt;
  logic [15:0] data_in;
  logic [15:0] result;
  logic        conv_done;
  logic        load_a;
  logic        load_b;
  logic        load_op;
  logic        show_result;
  logic        conv_start;
  logic [15:0] conv_value;
  logic        disp_valid;
  logic [2:0]  status;

  int ntests = 0;
  int nfail  = 0;
  int nstarts = 0;
  int ccnt = 0;

  logic [15:0] ra = 16'h0;
  logic [15:0] rb = 16'h0;
  logic [15:0] rop = 16'h0;

  sexp_t       sq[$];
  logic [15:0] cq[$];
  sexp_t       se;
  vec_t        tbl[13];

  rpn_sequencer #(.W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .enter          (enter),
    .undo           (undo),
    .display_format (fmt),
    .data_in        (data_in),
    .result         (result),
    .conv_done      (conv_done),
    .load_a         (load_a),
    .load_b         (load_b),
    .load_op        (load_op),
    .show_result    (show_result),
    .conv_start     (conv_start),
    .conv_value     (conv_value),
    .disp_valid     (disp_valid),
    .status         (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: op 1 subtracts, anything else adds
  always @(posedge clk) begin
    if (load_a)  ra  <= data_in;
    if (load_b)  rb  <= data_in;
    if (load_op) rop <= data_in;
  end
  assign result = (rop == 16'h0001) ? ra - rb : ra + rb;

  // converter model, 20-cycle latency, unaffected by reset
  always @(posedge clk) begin
    if (conv_start)    ccnt <= 20;
    else if (ccnt > 0) ccnt <= ccnt - 1;
  end
  assign conv_done = (ccnt == 1);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard consumers
  always @(negedge clk) begin
    if (load_a | load_b | load_op) begin
      if (sq.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL strobe: got unexpected %b expected none",
                 {load_a, load_b, load_op});
      end else begin
        se = sq.pop_front();
        chk("strobe", {29'd0, load_a, load_b, load_op}, {29'd0, se.sb});
        chk("strobe_status", {29'd0, status}, {29'd0, se.st});
      end
    end
    if (conv_start) begin
      nstarts++;
      if (cq.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL conv_start: got unexpected %h expected none",
                 conv_value);
      end else begin
        chk("conv_value", {16'd0, conv_value}, {16'd0, cq.pop_front()});
      end
    end
  end

  task automatic press(input logic e, input logic u);
    @(negedge clk);
    enter = e;
    undo  = u;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    undo  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_for(input string nm, input bit on_done,
                          input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (on_done ? conv_done : conv_start) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit bad;
    bit seen;
    int st0;

    tbl = '{
      '{1'b1, 1'b0, 16'hFFFF, 3'b010, 3'b100},
      '{1'b1, 1'b0, 16'h005A, 3'b100, 3'b010},
      '{1'b1, 1'b0, 16'h0001, 3'b111, 3'b001},
      '{1'b0, 1'b1, 16'h0001, 3'b100, 3'b000},
      '{1'b0, 1'b1, 16'h0001, 3'b010, 3'b000},
      '{1'b0, 1'b1, 16'h0001, 3'b001, 3'b000},
      '{1'b0, 1'b1, 16'h0001, 3'b001, 3'b000},
      '{1'b1, 1'b0, 16'hFFFF, 3'b010, 3'b100},
      '{1'b1, 1'b0, 16'h005A, 3'b100, 3'b010},
      '{1'b1, 1'b1, 16'h0001, 3'b010, 3'b000},
      '{1'b1, 1'b0, 16'h005A, 3'b100, 3'b010},
      '{1'b1, 1'b0, 16'h0001, 3'b111, 3'b001},
      '{1'b1, 1'b0, 16'h0001, 3'b001, 3'b000}
    };

    reset   = 1'b1;
    enter   = 1'b0;
    undo    = 1'b0;
    fmt     = 1'b0;
    data_in = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_status", {29'd0, status}, 32'd1);
    chk("rst_strobes", {29'd0, load_a, load_b, load_op}, 32'd0);
    chk("rst_show", {31'd0, show_result}, 32'd0);
    chk("rst_start", {31'd0, conv_start}, 32'd0);
    chk("rst_value", {16'd0, conv_value}, 32'd0);
    chk("rst_valid", {31'd0, disp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      data_in = tbl[i].d;
      if (tbl[i].sb != 3'b000) sq.push_back('{tbl[i].sb, tbl[i].st});
      press(tbl[i].e, tbl[i].u);
      chk($sformatf("vec%0d_status", i), {29'd0, status},
          {29'd0, tbl[i].st});
      chk($sformatf("vec%0d_show", i), {31'd0, show_result},
          {31'd0, tbl[i].st == 3'b111});
    end
    chk("hex_valid", {31'd0, disp_valid}, 32'd1);

    // enter held through reset gives no event
    @(negedge clk);
    reset = 1'b1;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_status", {29'd0, status}, 32'd1);
    enter = 1'b0;
    @(negedge clk);
    data_in = 16'h1111;
    sq.push_back('{3'b100, 3'b010});
    press(1'b1, 1'b0);
    chk("held_press_status", {29'd0, status}, 32'd2);

    // conversion handshake on FFFF
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    data_in = 16'hFFFF;
    cq.push_back(16'hFFFF);
    fmt = 1'b1;
    wait_for("start_ffff", 1'b0, 5);
    chk("run_valid", {31'd0, disp_valid}, 32'd0);
    wait_for("done_ffff", 1'b1, 40);
    chk("done_valid", {31'd0, disp_valid}, 32'd0);
    @(negedge clk);
    chk("valid_after_done", {31'd0, disp_valid}, 32'd1);

    // enter the operation, then the result needs conversion
    sq.push_back('{3'b100, 3'b010});
    press(1'b1, 1'b0);
    chk("same_dv_valid", {31'd0, disp_valid}, 32'd1);
    fmt = 1'b0;
    data_in = 16'h005A;
    sq.push_back('{3'b010, 3'b100});
    press(1'b1, 1'b0);
    data_in = 16'h0001;
    sq.push_back('{3'b001, 3'b111});
    press(1'b1, 1'b0);
    chk("hex_valid2", {31'd0, disp_valid}, 32'd1);
    cq.push_back(16'hFFA5);
    fmt = 1'b1;
    wait_for("start_ffa5", 1'b0, 5);
    wait_for("done_ffa5", 1'b1, 40);
    @(negedge clk);
    chk("valid_ffa5", {31'd0, disp_valid}, 32'd1);

    // data change during a running conversion
    fmt = 1'b0;
    press(1'b1, 1'b0);
    chk("wrap_status", {29'd0, status}, 32'd1);
    data_in = 16'hFFFF;
    cq.push_back(16'hFFFF);
    fmt = 1'b1;
    wait_for("start_run", 1'b0, 5);
    repeat (5) @(negedge clk);
    data_in = 16'h005A;
    cq.push_back(16'h005A);
    st0  = nstarts;
    bad  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (disp_valid) bad = 1'b1;
      if (conv_done) seen = 1'b1;
    end
    chk("done_run", {31'd0, seen}, 32'd1);
    chk("no_early_start", nstarts, st0);
    @(negedge clk);
    chk("restart_c1", {31'd0, conv_start}, 32'd0);
    if (disp_valid) bad = 1'b1;
    @(negedge clk);
    chk("restart_c2", {31'd0, conv_start}, 32'd1);
    if (disp_valid) bad = 1'b1;
    chk("valid_low_run", {31'd0, bad}, 32'd0);
    wait_for("done_5a", 1'b1, 40);
    @(negedge clk);
    chk("valid_5a", {31'd0, disp_valid}, 32'd1);

    // reset mid-conversion, late done must be ignored
    data_in = 16'h1234;
    cq.push_back(16'h1234);
    wait_for("start_1234", 1'b0, 5);
    repeat (5) @(negedge clk);
    reset   = 1'b1;
    fmt     = 1'b0;
    data_in = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_status", {29'd0, status}, 32'd1);
    chk("mid_rst_value", {16'd0, conv_value}, 32'd0);
    wait_for("late_done", 1'b1, 30);
    @(negedge clk);
    chk("late_hex_valid", {31'd0, disp_valid}, 32'd1);
    cq.push_back(16'h0000);
    fmt = 1'b1;
    wait_for("start_after_late", 1'b0, 5);
    wait_for("done_after_late", 1'b1, 40);
    @(negedge clk);
    chk("valid_after_late", {31'd0, disp_valid}, 32'd1);

    repeat (3) @(negedge clk);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("conv_queue_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Control FSM for the RPN calculator datapath. It turns the debounced `enter` and `undo` levels into one-cycle load strobes for the operand A, operand B and opcode registers, and tracks the entry state. It selects whether the display shows `data_in` or the ALU result. When decimal format is requested, it runs a start/done handshake with the binary-to-BCD converter. It sits between the debouncers and the datapath/display-driver.

## Interface
- `W`, 16, width of `data_in`, `result` and `conv_value`
- `clk` in 1: system clock.
- `reset` in 1: synchronous active-high reset.
- `enter` in 1: debounced Enter level.
- `undo` in 1: debounced Undo level.
- `display_format` in 1: 0 = hex (no conversion), 1 = decimal (conversion required).
- `data_in` in W: switch value.
- `result` in W: ALU output, combinational from the A/B/opcode registers.
- `conv_done` in 1: one-cycle pulse from the BCD converter when its conversion finishes.
- `load_a` out 1: one-cycle strobe that loads A from `data_in`.
- `load_b` out 1: one-cycle strobe that loads B from `data_in`.
- `load_op` out 1: one-cycle strobe that loads the opcode from `data_in`.
- `show_result` out 1: display mux select; 1 = `result`, 0 = `data_in`.
- `conv_start` out 1: one-cycle pulse that starts a conversion.
- `conv_value` out W: operand for the converter, held stable from `conv_start` until `conv_done`.
- `disp_valid` out 1: the display content matches the current display value.
- `status` out 3: current state code.

## Operation
- **States** (`rpn_pkg`):
  - `S_A`: `status` 3'b001.
  - `S_B`: `status` 3'b010.
  - `S_OP`: `status` 3'b100.
  - `S_RES`: `status` 3'b111.
- **Edge detection:** registered copies `enter_q` and `undo_q`.
  - An enter event is `enter & ~enter_q`; an undo event is defined the same way.
  - Reset sets `enter_q = undo_q = 1`. A button held through reset therefore gives no event until it is released and pressed again.
- **Enter transitions:**
  - `S_A` → `S_B` with `load_a`.
  - `S_B` → `S_OP` with `load_b`.
  - `S_OP` → `S_RES` with `load_op`.
  - `S_RES` → `S_A`, no strobe.
- **Undo transitions** (never a strobe):
  - `S_B` → `S_A`, `S_OP` → `S_B`, `S_RES` → `S_OP`.
  - `S_A` stays in `S_A`.
- **Simultaneous events:** when enter and undo occur in the same cycle, undo wins and the enter event is discarded.
- **Display select:** `show_result = (state == S_RES)`. The display value is `dv = show_result ? result : data_in`.
- **Conversion sub-FSM** (`C_IDLE`, `C_RUN`) with a `cv_ok` flag:
  - `need = display_format & (~cv_ok | dv != conv_value)`.
  - In `C_IDLE` with `need`: pulse `conv_start`, capture `conv_value <= dv`, clear `cv_ok`, go to `C_RUN`.
  - In `C_RUN`: ignore `dv` changes. On `conv_done`, set `cv_ok` and go to `C_IDLE`. If `dv` changed meanwhile, `need` is true again and a new start is issued on the next cycle.
  - `conv_done` received in `C_IDLE` is ignored.
- **Display valid:** registered `disp_valid = ~display_format | (C_IDLE & cv_ok & dv == conv_value)`.
- **Hex mode:** when `display_format` = 0, no starts are issued. A conversion already in flight still completes normally.

## Timing
- **Reset values:**
  - Outputs: `state=S_A`, `status=3'b001`, all strobes 0, `conv_start` 0, `show_result` 0, `conv_value` 0, `disp_valid` 0.
  - Internal: conversion FSM `C_IDLE`, `cv_ok` 0.
- **Load strobes:** an event sampled at edge k produces a strobe high during cycle k+1. `status` changes at that same edge k. Exactly one strobe is asserted per accepted event.
- **Converter start:** `conv_start` is registered and is high for exactly one cycle. `conv_value` is updated at the same edge.
- **Earliest restart:**
  - The earliest new `conv_start` comes 2 cycles after the `conv_done` sample.
  - `disp_valid` rises 1 cycle after `conv_done` if `dv` is unchanged.
  - `disp_valid` drops 1 cycle after `dv` changes or `display_format` rises.
- **Reset mid-conversion:** the FSM returns to `C_IDLE` and a late `conv_done` is ignored.
- **Converter latency:** the block works with any converter latency of 1 cycle or more; it has no timeout.

## Structure
- **Package `rpn_pkg`:** holds the `state_t` enum (`S_A`, `S_B`, `S_OP`, `S_RES`), the `conv_t` enum (`C_IDLE`, `C_RUN`) and the `STATUS_*` localparams.
- **Sub-module `rise_detect`:** registered rising-edge detector with a reset value of 1, instantiated for `enter` and `undo`.
- **Top level:** everything else is a single `always_ff` block plus an `always_comb` next-state block.

## Test plan
- **Full sequence:**
  - Stimulus: after reset, `data_in`=16'hFFFF with an enter press, then 16'h005A with enter, then 16'h0001 with enter.
  - Required: `load_a`, then `load_b`, then `load_op`, each 1 cycle wide. `status` steps 001 → 010 → 100 → 111 and `show_result`=1.
- **Undo chain:**
  - Stimulus: from `S_RES`, three undo presses, then a fourth.
  - Required: `status` 111 → 100 → 010 → 001 and stays at 001. No strobe is asserted.
- **Simultaneous press:**
  - Stimulus: `enter` and `undo` rise in the same cycle while in `S_OP`.
  - Required: next state is `S_B` and `load_op` stays 0.
- **Held through reset:**
  - Stimulus: `enter`=1 during reset and for 10 cycles after it.
  - Required: no `load_a` and the state stays `S_A`.
  - Stimulus: release then press `enter`.
  - Required: one `load_a`.
- **Conversion handshake:**
  - Stimulus: `display_format`=1, `data_in`=16'hFFFF, converter model with 20-cycle latency.
  - Required: one `conv_start` with `conv_value`=16'hFFFF. `disp_valid` goes high 1 cycle after `conv_done`.
  - Stimulus: after entering the result, `dv` becomes 16'hFFA5.
  - Required: a new start with `conv_value`=16'hFFA5.
- **Change during run:**
  - Stimulus: change `data_in` to 16'h005A 5 cycles after `conv_start`.
  - Required: no second start before `conv_done`. A second `conv_start` with 16'h005A follows 2 cycles after `conv_done`, and `disp_valid` stays 0 throughout.
